// File: rtl/cv32e40s_mdu_seq_if.sv
// Handshake bundle between the EX stage and the multicycle M unit.
// Request side flows master->slave, result side slave->master.
interface cv32e40s_mdu_seq_if #(
  parameter int DATA_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [2:0]        funct3_i;
  logic [DATA_W-1:0] op_a_i;
  logic [DATA_W-1:0] op_b_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] result_o;
  logic              illegal_o;
  logic              busy_o;

  modport master (
    output in_valid_i, funct3_i, op_a_i, op_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, illegal_o, busy_o
  );

  modport slave (
    input  in_valid_i, funct3_i, op_a_i, op_b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, illegal_o, busy_o
  );
endinterface

// File: rtl/cv32e40s_mdu_seq.sv
// Multicycle RV32M unit: registered multiply, radix-2 restoring divide.
// Result is held in DONE until consumed; kill_i aborts any state.
module cv32e40s_mdu_seq #(
  parameter int    DATA_W = 32,
  parameter string M_EXT  = "M"
) (
  input logic               clk,
  input logic               rst_n,
  input logic               kill_i,
  cv32e40s_mdu_seq_if.slave bus
);
  localparam int CW    = $clog2(DATA_W);
  localparam int PW    = 2*DATA_W + 2;
  localparam bit ZMMUL = (M_EXT == "ZMMUL");

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_DIV_FIX, S_DONE
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W-1:0] r_result;
  logic [CW-1:0]     r_cnt;
  logic              r_sa;
  logic              r_sb;
  logic              r_hi;
  logic              r_is_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_out_valid;
  logic              r_illegal;

  logic              w_accept;
  logic              w_is_div;
  logic              w_sgn;
  logic              w_rem_op;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_min;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic [DATA_W-1:0] w_q_next;
  logic [DATA_W-1:0] w_r_next;
  logic [DATA_W:0]   w_ma;
  logic [DATA_W:0]   w_mb;
  logic [DATA_W:0]   w_sh;
  logic [DATA_W:0]   w_diff;
  logic [PW-1:0]     w_prod;
  logic              w_unused;

  assign bus.in_ready_o  = (r_state == S_IDLE) && !kill_i;
  assign bus.out_valid_o = r_out_valid;
  assign bus.result_o    = r_result;
  assign bus.illegal_o   = r_illegal;
  assign bus.busy_o      = (r_state != S_IDLE);

  assign w_accept = bus.in_valid_i && bus.in_ready_o;
  assign w_is_div = bus.funct3_i[2];
  assign w_sgn    = !bus.funct3_i[0];
  assign w_rem_op = bus.funct3_i[1];
  assign w_min    = {1'b1, {(DATA_W-1){1'b0}}};
  assign w_a_neg  = w_sgn && bus.op_a_i[DATA_W-1];
  assign w_b_neg  = w_sgn && bus.op_b_i[DATA_W-1];
  assign w_abs_a  = w_a_neg ? -bus.op_a_i : bus.op_a_i;
  assign w_abs_b  = w_b_neg ? -bus.op_b_i : bus.op_b_i;
  assign w_b_zero = (bus.op_b_i == '0);
  assign w_ovf    = w_sgn && (bus.op_a_i == w_min)
                    && (bus.op_b_i == '1);

  // Multiply operands live in r_quot/r_dvs while in MUL.
  assign w_ma   = {r_sa & r_quot[DATA_W-1], r_quot};
  assign w_mb   = {r_sb & r_dvs[DATA_W-1], r_dvs};
  assign w_prod = {{(DATA_W+1){w_ma[DATA_W]}}, w_ma}
                * {{(DATA_W+1){w_mb[DATA_W]}}, w_mb};
  assign w_unused = ^w_prod[PW-1:2*DATA_W];

  // Partial remainder stays below the divisor, so DATA_W+1 bits suffice.
  assign w_sh     = {r_rem, r_quot[DATA_W-1]};
  assign w_diff   = w_sh - {1'b0, r_dvs};
  assign w_q_next = {r_quot[DATA_W-2:0], !w_diff[DATA_W]};
  assign w_r_next = w_diff[DATA_W] ? w_sh[DATA_W-1:0]
                                   : w_diff[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_hi        <= 1'b0;
      r_is_rem    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (kill_i) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_rem  <= w_rem_op;
            r_illegal <= 1'b0;
            if (!w_is_div) begin
              r_state <= S_MUL;
              r_quot  <= bus.op_a_i;
              r_dvs   <= bus.op_b_i;
              r_sa    <= (bus.funct3_i == 3'b001)
                      || (bus.funct3_i == 3'b010);
              r_sb    <= (bus.funct3_i == 3'b001);
              r_hi    <= (bus.funct3_i[1:0] != 2'b00);
            end else if (ZMMUL) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= '0;
              r_illegal   <= 1'b1;
            end else if (w_b_zero) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_rem_op ? bus.op_a_i : '1;
            end else if (w_ovf) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_rem_op ? '0 : bus.op_a_i;
            end else begin
              r_state <= S_DIV;
              r_quot  <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_rem   <= '0;
              r_cnt   <= CW'(DATA_W-1);
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end
          end
        end
        S_MUL: begin
          r_result    <= r_hi ? w_prod[2*DATA_W-1:DATA_W]
                              : w_prod[DATA_W-1:0];
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end
        S_DIV: begin
          r_quot <= w_q_next;
          r_rem  <= w_r_next;
          if (r_cnt == '0) r_state <= S_DIV_FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_DIV_FIX: begin
          if (r_is_rem) r_result <= r_neg_r ? -r_rem : r_rem;
          else          r_result <= r_neg_q ? -r_quot : r_quot;
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready_i) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
